// File: rtl/gcd_job_if.sv
// gcd_job_if: job-in, engine start/done and result-out signals of the GCD dispatcher.
// master = dispatcher side, slave = job source / engine / consumer side.
interface gcd_job_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 eng_start;
    logic [WIDTH-1:0]     eng_a;
    logic [WIDTH-1:0]     eng_b;
    logic                 eng_done;
    logic [WIDTH-1:0]     eng_gcd;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_gcd;
    logic                 out_err;
    logic                 busy;
    logic [CNT_WIDTH-1:0] job_count;

    modport master (
        input  in_valid, in_a, in_b, eng_done, eng_gcd, out_ready,
        output in_ready, eng_start, eng_a, eng_b, out_valid, out_gcd, out_err, busy, job_count
    );
    modport slave (
        output in_valid, in_a, in_b, eng_done, eng_gcd, out_ready,
        input  in_ready, eng_start, eng_a, eng_b, out_valid, out_gcd, out_err, busy, job_count
    );
endinterface

// File: rtl/gcd_job_dispatcher.sv
// gcd_job_dispatcher: feeds one job at a time to a GCD engine via start/done and returns the result.
// Define GCD_TIMEOUT_EN to enable the WAIT-state watchdog (out_err on timeout).
module gcd_job_dispatcher #(
    parameter int WIDTH          = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    gcd_job_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t state, state_nxt;
    logic   in_hs, out_hs, zero_op, timeout, load;

    assign in_hs   = state == IDLE && bus.in_valid;
    assign out_hs  = state == OUT && bus.out_ready;
    assign zero_op = bus.in_a == {WIDTH{1'b0}} || bus.in_b == {WIDTH{1'b0}};
    // Result register is loaded either by the zero-operand bypass or by the end of WAIT
    assign load    = (in_hs && zero_op) || (state == WAIT && (bus.eng_done || timeout));

    assign bus.in_ready = state == IDLE;
    assign bus.busy     = state != IDLE;

`ifdef GCD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    assign timeout = state == WAIT && !bus.eng_done && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            bus.out_err <= 1'b0;
        end else begin
            wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
            if (in_hs || state == WAIT) bus.out_err <= timeout;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign bus.out_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? (zero_op ? OUT : ISSUE) : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = bus.eng_done || timeout ? OUT : WAIT;
            OUT:     state_nxt = bus.out_ready ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_start <= 1'b0;
            bus.eng_a     <= {WIDTH{1'b0}};
            bus.eng_b     <= {WIDTH{1'b0}};
            bus.out_valid <= 1'b0;
            bus.out_gcd   <= {WIDTH{1'b0}};
            bus.job_count <= {CNT_WIDTH{1'b0}};
        end else begin
            bus.eng_start <= in_hs && !zero_op;
            if (in_hs) begin
                bus.eng_a <= bus.in_a;
                bus.eng_b <= bus.in_b;
            end
            if (in_hs && zero_op) bus.out_gcd <= bus.in_a | bus.in_b;
            else if (load)        bus.out_gcd <= timeout ? {WIDTH{1'b0}} : bus.eng_gcd;
            bus.out_valid <= load || (bus.out_valid && !out_hs);
            if (out_hs) bus.job_count <= bus.job_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// tb_gcd_job_dispatcher: table, hand-written and random jobs against a behavioural GCD engine
// and a Euclid reference; timeout branch follows GCD_TIMEOUT_EN.
module tb_gcd_job_dispatcher;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gcd_job_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
    gcd_job_dispatcher #(.WIDTH(W), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int jobs_done = 0;

    function automatic logic [15:0] gcd_ref(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural engine: result after eng_lat cycles, optional stub mode never answers,
    // inj_done forces spurious done pulses carrying a garbage result.
    int          eng_lat = 0;
    bit          stub = 1'b0;
    int          starts = 0;
    bit          ops_stable = 1'b1;
    logic        inj_done = 1'b0;
    logic        mdone;
    logic [15:0] mgcd, ea, eb;
    int          cnt;
    bit          pend;

    assign bus.eng_done = mdone | inj_done;
    assign bus.eng_gcd  = mdone ? mgcd : 16'hBEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdone <= 1'b0;
            mgcd  <= '0;
            pend  <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (bus.eng_start) begin
                ea     <= bus.eng_a;
                eb     <= bus.eng_b;
                starts <= starts + 1;
                if (eng_lat == 0) begin
                    mdone <= !stub;
                    mgcd  <= gcd_ref(bus.eng_a, bus.eng_b);
                end else begin
                    pend <= 1'b1;
                    cnt  <= eng_lat - 1;
                end
            end else if (pend) begin
                if (bus.eng_a !== ea || bus.eng_b !== eb) ops_stable <= 1'b0;
                if (cnt == 0) begin
                    pend  <= 1'b0;
                    mdone <= !stub;
                    mgcd  <= gcd_ref(ea, eb);
                end else cnt <= cnt - 1;
            end
        end
    end

    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int lat,
                           input int hold, input logic [15:0] exp_g);
        int cyc;
        int s0;
        bit z;
        bit stable;
        logic [15:0] g0;
        z = a == 0 || b == 0;
        eng_lat = lat;
        cyc = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready before job", bus.in_ready, 1);
        s0 = starts;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("result latency", cyc, z ? 1 : 3 + lat);
        check("out_gcd", bus.out_gcd, exp_g);
        check("out_err", bus.out_err, 0);
        check("eng_start count", starts - s0, z ? 0 : 1);
        g0 = bus.out_gcd;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_gcd !== g0 || bus.in_ready) stable = 1'b0;
        end
        if (hold > 0) check("result held", stable, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        jobs_done++;
        check("job_count", bus.job_count, jobs_done % 256);
        check("eng_a/eng_b hold", {bus.eng_a, bus.eng_b}, {a, b});
        check("idle after job", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
    endtask

    task automatic wait_out_valid(input int limit, output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset outputs", {bus.eng_start, bus.eng_a, bus.eng_b, bus.out_valid, bus.out_gcd,
                                bus.out_err, bus.busy, bus.in_ready, bus.job_count},
              {1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h0});
        #4 rst_n = 1'b1;
        jobs_done = 0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic [15:0] g;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cyc;
        int s0;
        bit stable;
        logic [15:0] a, b, k;
        tbl[0] = '{16'd1,     16'd1,   0, 16'd1};
        tbl[1] = '{16'd24,    16'd196, 1, 16'd4};
        tbl[2] = '{16'd10000, 16'd625, 5, 16'd625};
        tbl[3] = '{16'd45,    16'd200, 2, 16'd5};
        tbl[4] = '{16'd36,    16'd36,  0, 16'd36};
        tbl[5] = '{16'd128,   16'd9,   7, 16'd1};
        tbl[6] = '{16'd0,     16'd36,  0, 16'd36};
        tbl[7] = '{16'd0,     16'd0,   0, 16'd0};

        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset outputs", {bus.eng_start, bus.eng_a, bus.eng_b, bus.out_valid, bus.out_gcd,
                                bus.out_err, bus.busy, bus.in_ready, bus.job_count},
              {1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h0});
        #8 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (i == 6) s0 = starts;
            run_job(tbl[i].a, tbl[i].b, tbl[i].lat, i % 3, tbl[i].g);
            if (i == 5) check("six engine jobs counted", bus.job_count, 6);
        end
        check("no start for zero operands", starts - s0, 0);

        // Consumer stalls 20 cycles while the next job waits at the input
        eng_lat = 2;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 16'd24;
        bus.in_b = 16'd196;
        @(negedge clk);
        bus.in_a = 16'd36;
        bus.in_b = 16'd36;
        wait_out_valid(100, cyc);
        check("stall result", bus.out_gcd, 4);
        s0 = starts;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            inj_done = i == 10;
            @(negedge clk);
            if (!bus.out_valid || bus.out_gcd !== 16'd4 || bus.in_ready || !bus.busy) stable = 1'b0;
        end
        inj_done = 1'b0;
        check("stall holds output, refuses job", stable, 1);
        check("no start during stall", starts - s0, 0);
        eng_lat = 3;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        jobs_done++;
        check("idle one cycle after handshake", {bus.in_ready, bus.out_valid}, 2'b10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("queued job issued", {bus.eng_start, bus.busy}, 2'b11);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        wait_out_valid(100, cyc);
        check("queued job result", bus.out_gcd, 36);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        jobs_done++;
        check("job_count after stall", bus.job_count, jobs_done % 256);

        // Reset while the engine is still working
        eng_lat = 40;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 16'd100;
        bus.in_b = 16'd75;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("in WAIT before reset", {bus.busy, bus.out_valid}, 2'b10);
        reset_pulse();
        run_job(16'd24, 16'd196, 1, 0, 16'd4);

        // Engine that never answers
        stub = 1'b1;
        eng_lat = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 16'd24;
        bus.in_b = 16'd196;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stub job issued", bus.eng_start, 1);
`ifdef GCD_TIMEOUT_EN
        @(negedge clk);
        wait_out_valid(200, cyc);
        check("timeout after WAIT cycles", cyc, TO);
        check("timeout result", {bus.out_err, bus.out_gcd}, {1'b1, 16'h0});
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        check("late done ignored", {bus.out_valid, bus.out_err, bus.out_gcd}, {1'b1, 1'b1, 16'h0});
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        jobs_done++;
        check("timeout job counted", bus.job_count, jobs_done % 256);
        stub = 1'b0;
`else
        repeat (60) @(negedge clk);
        check("waits forever without done", {bus.busy, bus.out_valid, bus.out_err}, 3'b100);
        stub = 1'b0;
        reset_pulse();
`endif

        for (int i = 0; i < 40; i++) begin
            k = 16'($urandom_range(1, 40));
            a = i % 2 ? k * 16'($urandom_range(1, 500)) : 16'($urandom_range(1, 65535));
            b = i % 2 ? k * 16'($urandom_range(1, 500)) : 16'($urandom_range(1, 65535));
            if (i % 9 == 4) a = 16'h0;
            run_job(a, b, $urandom_range(0, 6), $urandom_range(0, 3), gcd_ref(a, b));
        end

        // Enough bypass jobs to wrap the 8-bit counter
        for (int i = 0; i < 260; i++) begin
            b = 16'($urandom);
            run_job(16'h0, b, 0, 0, b);
        end
        check("operands stable while engine busy", ops_stable, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
